// File: rtl/cpc_mem_pkg.sv
// Shared SRAM arbiter types: sequencer states, requester ids and a priority helper.
// Combinational only; no latency or backpressure of its own.
package cpc_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } state_t;

  localparam int RQ_VID  = 0;
  localparam int RQ_CPU  = 1;
  localparam int RQ_BOOT = 2;
  localparam int NUM_RQ  = 3;

  typedef logic [NUM_RQ-1:0] rq_vec_t;

  localparam rq_vec_t BOOT_ONLY = rq_vec_t'(1 << RQ_BOOT);

  // Isolate the lowest set bit; bit 0 is the highest priority requester.
  function automatic rq_vec_t first_one(input rq_vec_t v);
    return v & (~v + rq_vec_t'(1));
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes (req held until 1-cycle ack) plus the SRAM pin bundle.
// master = requester/pad side, slave = arbiter side.
interface sram_arbiter_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 8
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_dout;

  logic              boot_req;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_data;
  logic              boot_ack;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] sram_din;
  logic              sram_oe;
  logic              sram_we_n;

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    output boot_req, boot_addr, boot_data, sram_din,
    input  vid_ack, vid_data, cpu_ack, cpu_dout, boot_ack,
    input  sram_addr, sram_dout, sram_oe, sram_we_n
  );

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    input  boot_req, boot_addr, boot_data, sram_din,
    output vid_ack, vid_data, cpu_ack, cpu_dout, boot_ack,
    output sram_addr, sram_dout, sram_oe, sram_we_n
  );
endinterface

// File: rtl/sram_prio_arb.sv
// Fixed-priority grant vid > cpu > boot; before boot_done only boot may win.
// Combinational, zero latency; ungranted requests simply stay pending.
module sram_prio_arb
  import cpc_mem_pkg::*;
(
  input  rq_vec_t req,
  input  rq_vec_t mask,
  input  logic    boot_done,
  output rq_vec_t gnt,
  output logic    vld
);

  rq_vec_t elig;

  always_comb begin
    elig = req & ~mask;
    if (!boot_done) elig = elig & BOOT_ONLY;
    gnt = first_one(elig);
    vld = |elig;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises video/CPU/boot requesters onto one SRAM via SETUP/STROBE/RECOVER.
// Ack ACC_CYC+2 cycles after the grant edge; losers hold req until served.
module sram_arbiter
  import cpc_mem_pkg::*;
#(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 8,
  parameter int ACC_CYC = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          boot_done,
  output logic          busy,
  sram_arbiter_if.slave bus
);

  localparam logic [3:0] ACC_LD = 4'(ACC_CYC);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  rq_vec_t           lat_id, mask, gnt;
  logic              gnt_vld, load;
  logic [ADDR_W-1:0] lat_addr, sel_addr;
  logic [DATA_W-1:0] lat_data, sel_data;
  logic              lat_we, sel_we;

  // Only the requester just served is masked, and only while its req is still up.
  assign mask = (state == ST_RECOVER) ? lat_id : '0;

  sram_prio_arb u_arb (
    .req       ({bus.boot_req, bus.cpu_req, bus.vid_req}),
    .mask      (mask),
    .boot_done (boot_done),
    .gnt       (gnt),
    .vld       (gnt_vld)
  );

  always_comb begin
    sel_addr = bus.boot_addr;
    sel_data = bus.boot_data;
    sel_we   = 1'b1;
    if (gnt[RQ_VID]) begin
      sel_addr = bus.vid_addr;
      sel_data = '0;
      sel_we   = 1'b0;
    end else if (gnt[RQ_CPU]) begin
      sel_addr = bus.cpu_addr;
      sel_data = bus.cpu_din;
      sel_we   = bus.cpu_we;
    end
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    bus.vid_ack   = 1'b0;
    bus.cpu_ack   = 1'b0;
    bus.boot_ack  = 1'b0;
    bus.sram_we_n = 1'b1;
    bus.sram_oe   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (gnt_vld) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
        end
      end
      ST_SETUP: begin
        bus.sram_oe = lat_we;
        state_nxt   = ST_STROBE;
      end
      ST_STROBE: begin
        bus.sram_oe   = lat_we;
        bus.sram_we_n = !lat_we;
        if (cnt <= 4'd1) state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        bus.sram_oe  = lat_we;
        bus.vid_ack  = lat_id[RQ_VID];
        bus.cpu_ack  = lat_id[RQ_CPU];
        bus.boot_ack = lat_id[RQ_BOOT];
        if (gnt_vld) begin
          state_nxt = ST_SETUP;
          load      = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      lat_id       <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_we       <= 1'b0;
      bus.vid_data <= '0;
      bus.cpu_dout <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        lat_id   <= gnt;
        lat_addr <= sel_addr;
        lat_data <= sel_data;
        lat_we   <= sel_we;
      end
      if (state == ST_SETUP) cnt <= ACC_LD;
      else if (state == ST_STROBE && cnt != 4'd0) cnt <= cnt - 4'd1;
      // Read data is captured at the close of the final strobe cycle.
      if (state == ST_STROBE && cnt <= 4'd1 && !lat_we) begin
        if (lat_id[RQ_VID]) bus.vid_data <= bus.sram_din;
        if (lat_id[RQ_CPU]) bus.cpu_dout <= bus.sram_din;
      end
    end
  end

  assign bus.sram_addr = lat_addr;
  assign bus.sram_dout = bus.sram_oe ? lat_data : '0;
  assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed tables, corner sequences and
// randomised request batches against an ordered-service memory model.
module tb_sram_arbiter;

  localparam int ACC = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic bd2, bd1, bd15;
  logic busy2, busy1, busy15;

  sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) i2 ();
  sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) i1 ();
  sram_arbiter_if #(.ADDR_W(21), .DATA_W(8)) i15 ();

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACC_CYC(ACC)) u_d2 (
    .clk(clk), .reset_n(reset_n), .boot_done(bd2), .busy(busy2), .bus(i2));
  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACC_CYC(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .boot_done(bd1), .busy(busy1), .bus(i1));
  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .ACC_CYC(15)) u_d15 (
    .clk(clk), .reset_n(reset_n), .boot_done(bd15), .busy(busy15), .bus(i15));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Unwritten locations read back as a fixed pattern of their address.
  function automatic logic [7:0] dflt(input logic [20:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Behavioural SRAM on the main DUT's pins.
  logic [7:0] sram_mem [logic [20:0]];
  logic       ovr_en;
  logic [7:0] ovr_val;

  always @(negedge clk) begin
    if (!i2.sram_we_n) sram_mem[i2.sram_addr] = i2.sram_dout;
    if (ovr_en) i2.sram_din <= ovr_val;
    else if (sram_mem.exists(i2.sram_addr)) i2.sram_din <= sram_mem[i2.sram_addr];
    else i2.sram_din <= dflt(i2.sram_addr);
  end

  // Reference model: memory contents as seen by requesters in service order.
  logic [7:0] model_mem [logic [20:0]];

  function automatic logic [7:0] model_rd(input logic [20:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  // Raise a set of requests together on an idle arbiter; served in priority
  // order, one access every ACC+2 cycles; each req drops the cycle after its ack.
  task automatic run_batch(input logic [2:0] which, input logic cwe,
                           input logic [20:0] va, input logic [20:0] ca, input logic [7:0] cd,
                           input logic [20:0] ba, input logic [7:0] bd);
    logic [7:0] exp_d [3];
    int         exp_c [3];
    logic [2:0] pend, drop, acks;
    int         k, cyc;
    k = 0;
    for (int id = 0; id < 3; id++) begin
      exp_d[id] = 8'h00;
      exp_c[id] = 0;
      if (which[id]) begin
        k++;
        exp_c[id] = k * (ACC + 2);
        if (id == 0) exp_d[id] = model_rd(va);
        else if (id == 1 && !cwe) exp_d[id] = model_rd(ca);
        else if (id == 1) model_mem[ca] = cd;
        else model_mem[ba] = bd;
      end
    end
    i2.vid_addr = va;  i2.cpu_addr = ca; i2.cpu_din = cd; i2.cpu_we = cwe;
    i2.boot_addr = ba; i2.boot_data = bd;
    i2.vid_req = which[0]; i2.cpu_req = which[1]; i2.boot_req = which[2];
    pend = which;
    drop = 3'b000;
    cyc  = 0;
    while ((pend != 3'b000 || drop != 3'b000) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (drop[0]) i2.vid_req = 1'b0;
      if (drop[1]) i2.cpu_req = 1'b0;
      if (drop[2]) i2.boot_req = 1'b0;
      drop = 3'b000;
      acks = {i2.boot_ack, i2.cpu_ack, i2.vid_ack};
      check("spurious_ack", 32'(acks & ~pend), 32'h0);
      for (int id = 0; id < 3; id++) begin
        if (acks[id] && pend[id]) begin
          check("ack_cycle", cyc, exp_c[id]);
          if (id == 0) check("vid_rd_data", 32'(i2.vid_data), 32'(exp_d[id]));
          if (id == 1 && !cwe) check("cpu_rd_data", 32'(i2.cpu_dout), 32'(exp_d[id]));
          pend[id] = 1'b0;
          drop[id] = 1'b1;
        end
      end
    end
    check("batch_complete", 32'(pend), 32'h0);
    i2.vid_req = 1'b0; i2.cpu_req = 1'b0; i2.boot_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0]  who;
    logic        we;
    logic [20:0] addr;
    logic [7:0]  dat;
    logic [7:0]  exp;
  } acc_vec_t;

  typedef struct {
    logic we_n;
    logic oe;
    logic ack;
    logic busy;
  } cyc_vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    acc_vec_t    tbl [7];
    cyc_vec_t    wr_seq [5];
    logic [2:0]  which;
    logic [20:0] ra;
    int          back, vack, wl;

    tbl[0] = '{3'b100, 1'b1, 21'h00100, 8'h11, 8'h00};
    tbl[1] = '{3'b010, 1'b0, 21'h01234, 8'h00, 8'hA5};
    tbl[2] = '{3'b001, 1'b0, 21'h00100, 8'h00, 8'h11};
    tbl[3] = '{3'b010, 1'b1, 21'h00100, 8'h5E, 8'h00};
    tbl[4] = '{3'b001, 1'b0, 21'h00100, 8'h00, 8'h5E};
    tbl[5] = '{3'b010, 1'b0, 21'h00100, 8'h00, 8'h5E};
    tbl[6] = '{3'b001, 1'b0, 21'h00200, 8'h00, 8'h77};

    // SETUP, STROBE, STROBE, RECOVER, IDLE for a write with ACC_CYC=2.
    wr_seq[0] = '{1'b1, 1'b1, 1'b0, 1'b1};
    wr_seq[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    wr_seq[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    wr_seq[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    wr_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0;
    bd2 = 1'b0; bd1 = 1'b1; bd15 = 1'b1;
    ovr_en = 1'b0; ovr_val = 8'h00;
    i2.vid_req = 0;  i2.vid_addr = '0;  i2.cpu_req = 0;  i2.cpu_we = 0;
    i2.cpu_addr = '0; i2.cpu_din = '0;  i2.boot_req = 0; i2.boot_addr = '0; i2.boot_data = '0;
    i1.vid_req = 0;  i1.vid_addr = '0;  i1.cpu_req = 0;  i1.cpu_we = 0;
    i1.cpu_addr = '0; i1.cpu_din = '0;  i1.boot_req = 0; i1.boot_addr = '0; i1.boot_data = '0;
    i1.sram_din = 8'h77;
    i15.vid_req = 0; i15.vid_addr = '0; i15.cpu_req = 0; i15.cpu_we = 0;
    i15.cpu_addr = '0; i15.cpu_din = '0; i15.boot_req = 0; i15.boot_addr = '0; i15.boot_data = '0;
    i15.sram_din = 8'h77;

    repeat (3) @(posedge clk);
    #1;
    check("rst_vid_ack", 32'(i2.vid_ack), 32'h0);
    check("rst_cpu_ack", 32'(i2.cpu_ack), 32'h0);
    check("rst_boot_ack", 32'(i2.boot_ack), 32'h0);
    check("rst_we_n", 32'(i2.sram_we_n), 32'h1);
    check("rst_oe", 32'(i2.sram_oe), 32'h0);
    check("rst_addr", 32'(i2.sram_addr), 32'h0);
    check("rst_dout", 32'(i2.sram_dout), 32'h0);
    check("rst_vid_data", 32'(i2.vid_data), 32'h0);
    check("rst_cpu_dout", 32'(i2.cpu_dout), 32'h0);
    check("rst_busy", 32'(busy2), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Boot gating: only boot is served until boot_done rises.
    i2.vid_addr = 21'h00100; i2.vid_req = 1'b1;
    i2.boot_addr = 21'h00200; i2.boot_data = 8'h77; i2.boot_req = 1'b1;
    back = 0; wl = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (back != 0 && c == back + 1) i2.boot_req = 1'b0;
      if (!i2.sram_we_n) wl++;
      if (i2.boot_ack && back == 0) back = c;
      check("gate_no_vid_ack", 32'(i2.vid_ack), 32'h0);
    end
    check("gate_boot_ack_cycle", back, 4);
    check("gate_boot_we_low", wl, 2);
    model_mem[21'h00200] = 8'h77;
    bd2 = 1'b1;
    vack = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (vack != 0 && c == vack + 1) i2.vid_req = 1'b0;
      if (i2.vid_ack && vack == 0) begin
        vack = c;
        check("gate_vid_data", 32'(i2.vid_data), 32'(model_rd(21'h00100)));
      end
    end
    check("gate_vid_ack_cycle", vack, 4);

    // Priority with RECOVER->SETUP chaining.
    run_batch(3'b111, 1'b0, 21'h00400, 21'h00401, 8'h00, 21'h00402, 8'hB7);

    // CPU write, cycle by cycle; inputs change after the latch without effect.
    i2.cpu_we = 1'b1; i2.cpu_addr = 21'h01234; i2.cpu_din = 8'hA5; i2.cpu_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin i2.cpu_din = 8'h00; i2.cpu_addr = 21'h0; end
      if (i == 4) i2.cpu_req = 1'b0;
      check("wr_we_n", 32'(i2.sram_we_n), 32'(wr_seq[i].we_n));
      check("wr_oe", 32'(i2.sram_oe), 32'(wr_seq[i].oe));
      check("wr_ack", 32'(i2.cpu_ack), 32'(wr_seq[i].ack));
      check("wr_busy", 32'(busy2), 32'(wr_seq[i].busy));
      if (i < 4) begin
        check("wr_addr", 32'(i2.sram_addr), 32'h01234);
        check("wr_dout", 32'(i2.sram_dout), 32'hA5);
      end
    end
    model_mem[21'h01234] = 8'hA5;

    // Directed single accesses with hand-computed read data.
    foreach (tbl[t]) begin
      run_batch(tbl[t].who, tbl[t].we, tbl[t].addr, tbl[t].addr, tbl[t].dat,
                tbl[t].addr, tbl[t].dat);
      if (!tbl[t].we)
        check("tbl_rd", tbl[t].who[0] ? 32'(i2.vid_data) : 32'(i2.cpu_dout), 32'(tbl[t].exp));
    end

    // Read data must come from the final strobe cycle only, then hold.
    ovr_en = 1'b1; ovr_val = 8'hFF;
    i2.vid_addr = 21'h00300; i2.vid_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 3) ovr_val = 8'h3C;
      if (c == 4) begin
        ovr_val = 8'hFF;
        check("samp_ack", 32'(i2.vid_ack), 32'h1);
        check("samp_data", 32'(i2.vid_data), 32'h3C);
      end
      if (c == 5) i2.vid_req = 1'b0;
      if (c == 7) check("samp_hold", 32'(i2.vid_data), 32'h3C);
    end
    ovr_en = 1'b0;
    @(posedge clk); #1;

    // ACC_CYC=1 and ACC_CYC=15 builds: latency, strobe width, return to idle.
    for (int w = 0; w < 2; w++) begin
      int l1, l15, wl1, wl15;
      l1 = 0; l15 = 0; wl1 = 0; wl15 = 0;
      i1.cpu_we = w[0];  i1.cpu_addr = 21'h00040;  i1.cpu_din = 8'hC3;  i1.cpu_req = 1'b1;
      i15.cpu_we = w[0]; i15.cpu_addr = 21'h00040; i15.cpu_din = 8'hC3; i15.cpu_req = 1'b1;
      for (int c = 1; c <= 24; c++) begin
        @(posedge clk); #1;
        if (l1 != 0 && c == l1 + 1) i1.cpu_req = 1'b0;
        if (l15 != 0 && c == l15 + 1) begin
          i15.cpu_req = 1'b0;
          check("acc15_idle", 32'(busy15), 32'h0);
        end
        if (!i1.sram_we_n) wl1++;
        if (!i15.sram_we_n) wl15++;
        if (i1.cpu_ack && l1 == 0) l1 = c;
        if (i15.cpu_ack && l15 == 0) l15 = c;
      end
      check("acc1_latency", l1, 3);
      check("acc15_latency", l15, 17);
      if (w == 1) begin
        check("acc1_we_low", wl1, 1);
        check("acc15_we_low", wl15, 15);
      end else begin
        check("acc1_rd_data", 32'(i1.cpu_dout), 32'h77);
        check("acc15_rd_data", 32'(i15.cpu_dout), 32'h77);
      end
    end

    // Randomised batches; small address range forces read-after-write reuse.
    for (int b = 0; b < 40; b++) begin
      which = 3'($urandom_range(1, 7));
      ra    = 21'($urandom_range(0, 7));
      run_batch(which, 1'($urandom), 21'($urandom_range(0, 7)), ra, 8'($urandom),
                21'($urandom_range(0, 7)), 8'($urandom));
    end

    // Reset in the middle of a write strobe aborts without an ack.
    i2.cpu_we = 1'b1; i2.cpu_addr = 21'h1F000; i2.cpu_din = 8'h99; i2.cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_pre_we_n", 32'(i2.sram_we_n), 32'h0);
    #1 reset_n = 1'b0;
    #1;
    check("abort_we_n", 32'(i2.sram_we_n), 32'h1);
    check("abort_oe", 32'(i2.sram_oe), 32'h0);
    check("abort_busy", 32'(busy2), 32'h0);
    i2.cpu_req = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("abort_no_ack", 32'(i2.cpu_ack), 32'h0);
      check("abort_idle", 32'(busy2), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
